arena_memory: RTL and testbench
===============================

// Module: arena_memory
//
// PURPOSE
// Row-addressed bit-matrix holding the Life arena; the solver reads and writes it one row at a time.
// Second port serves the host/loader side for pattern entry, single-cell toggles and read-back for display.
// Built-in sequencer clears the whole arena or counts live cells, one row per cycle.
// Enforces port ownership so solver and host never write the array in the same cycle.
//
// PARAMETERS
// ARENA_WIDTH   10  cells per row (bits per row word); 1..256
// ARENA_HEIGHT  10  rows in arena; 1..256; ARENA_WIDTH*ARENA_HEIGHT <= 65535
//
// PORTS
// clk                  in   1   single clock, all state on rising edge
// reset                in   1   synchronous, active-high
// solver_active        in   1   1 = solver owns write access (tie to ~solver.ready)
// solver_row_select    in   8   solver row address
// solver_columns       out  W   mem[solver_row_select], combinational
// solver_columns_new   in   W   solver write data
// solver_columns_write in   1   solver row write strobe
// host_row_select      in   8   host row address
// host_col_select      in   8   host column for toggle
// host_columns         out  W   mem[host_row_select], combinational
// host_columns_new     in   W   host write data
// host_columns_write   in   1   host row write strobe
// host_cell_toggle     in   1   invert mem[host_row_select][host_col_select]
// host_denied          out  1   1-cycle pulse: host write/toggle dropped
// clear_start          in   1   request arena clear
// count_start          in   1   request population count
// busy                 out  1   sequencer running
// done                 out  1   1-cycle pulse: clear or count finished
// population           out  16  live-cell count from last completed count
//
// BEHAVIOUR
// - Reset (sync): all rows 0, FSM IDLE, busy=0, done=0, host_denied=0, population=0. Reset mid-operation aborts at that edge.
// - Reads combinational; row >= ARENA_HEIGHT reads all-zero.
// - Writes at rising edge. Row >= ARENA_HEIGHT or col >= ARENA_WIDTH: ignored silently, no host_denied.
// - Write gating: solver writes take effect only if solver_active=1 and busy=0.
//   Host write/toggle takes effect only if solver_active=0 and busy=0; otherwise dropped, host_denied=1 next cycle.
// - host_columns_write and host_cell_toggle together: row write wins, toggle ignored.
// - FSM IDLE -> CLEAR | COUNT -> IDLE; 8-bit row counter k.
//   IDLE: start sampled only when solver_active=0; clear_start and count_start together: CLEAR wins.
//   Starts while busy or solver_active=1 are ignored.
//   Start sampled at edge of cycle N: busy=1 in cycles N+1..N+H (H=ARENA_HEIGHT); edge ending cycle N+k processes row k-1.
//   CLEAR: writes row k-1 to 0. COUNT: acc += popcount(mem[k-1]); acc reset to 0 on entry.
//   Cycle N+H+1: busy=0, done=1 for one cycle; after COUNT, population=acc from that cycle, held until next count/reset.
//   Cleared rows are not otherwise visible before done; reads during CLEAR show partial progress.
// - solver_active rising while busy: sequencer completes; solver writes dropped until busy=0 (control must gate start on busy).
// - Accumulator 16 bits, cannot overflow given parameter limit.
//
// TESTING
// 1. Reset; read rows 0..9 via both ports -> all 10'h000; busy=0, population=0.
// 2. Host writes row 3 = 10'h2A5, toggles (3,0) -> row 3 reads 10'h2A4 on both ports next cycle.
// 3. solver_active=1, host writes row 5 = 10'h3FF -> row 5 unchanged, host_denied pulses 1 cycle; solver write row 5 = 10'h00F lands.
// 4. Load glider (5 cells), count_start -> busy 10 cycles, done pulse, population=5; clear_start+count_start same cycle -> clear runs.
// 5. clear_start after pattern -> exactly 10 busy cycles, all rows 0, done pulse; host write during CLEAR denied.
// 6. Row 12 read -> 0, write ignored without host_denied; reset asserted at cycle 4 of CLEAR -> all rows 0, busy=0 next cycle.

Source files
------------

// File: rtl/arena_memory_if.sv
// Solver, host and sequencer signal bundle for the Life arena memory.
// The master side drives requests; the slave side is the arena itself.
interface arena_memory_if #(
    parameter int unsigned ARENA_WIDTH = 10
);
    logic                   solver_active;
    logic [7:0]             solver_row_select;
    logic [ARENA_WIDTH-1:0] solver_columns;
    logic [ARENA_WIDTH-1:0] solver_columns_new;
    logic                   solver_columns_write;

    logic [7:0]             host_row_select;
    logic [7:0]             host_col_select;
    logic [ARENA_WIDTH-1:0] host_columns;
    logic [ARENA_WIDTH-1:0] host_columns_new;
    logic                   host_columns_write;
    logic                   host_cell_toggle;
    logic                   host_denied;

    logic                   clear_start;
    logic                   count_start;
    logic                   busy;
    logic                   done;
    logic [15:0]            population;

    modport master (
        output solver_active, solver_row_select, solver_columns_new, solver_columns_write,
        output host_row_select, host_col_select, host_columns_new, host_columns_write,
        output host_cell_toggle, clear_start, count_start,
        input  solver_columns, host_columns, host_denied, busy, done, population
    );

    modport slave (
        input  solver_active, solver_row_select, solver_columns_new, solver_columns_write,
        input  host_row_select, host_col_select, host_columns_new, host_columns_write,
        input  host_cell_toggle, clear_start, count_start,
        output solver_columns, host_columns, host_denied, busy, done, population
    );
endinterface

// File: rtl/arena_memory.sv
// Row-addressed Life arena with solver and host ports, write ownership arbitration,
// and a one-row-per-cycle sequencer for arena clear and live-cell count.
module arena_memory #(
    parameter int unsigned ARENA_WIDTH  = 10,
    parameter int unsigned ARENA_HEIGHT = 10
) (
    input  logic          clk,
    input  logic          reset,
    arena_memory_if.slave bus
);
    localparam int unsigned ROW_W = (ARENA_HEIGHT > 1) ? $clog2(ARENA_HEIGHT) : 1;
    localparam int unsigned COL_W = (ARENA_WIDTH > 1) ? $clog2(ARENA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, COUNT} state_t;

    logic [ARENA_WIDTH-1:0] mem [ARENA_HEIGHT];
    state_t                 state;
    logic [7:0]             k;
    logic [15:0]            acc;
    logic                   busy_q;
    logic                   done_q;
    logic                   denied_q;
    logic [15:0]            population_q;

    logic             solver_row_ok;
    logic             host_row_ok;
    logic             host_col_ok;
    logic [ROW_W-1:0] solver_idx;
    logic [ROW_W-1:0] host_idx;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] k_idx;
    logic             host_req;
    logic             host_grant;
    logic             solver_wr_ok;
    logic [15:0]      acc_next;

    assign solver_row_ok = {1'b0, bus.solver_row_select} < 9'(ARENA_HEIGHT);
    assign host_row_ok   = {1'b0, bus.host_row_select} < 9'(ARENA_HEIGHT);
    assign host_col_ok   = {1'b0, bus.host_col_select} < 9'(ARENA_WIDTH);
    assign solver_idx    = ROW_W'(bus.solver_row_select);
    assign host_idx      = ROW_W'(bus.host_row_select);
    assign col_idx       = COL_W'(bus.host_col_select);
    assign k_idx         = ROW_W'(k);

    // Out-of-range rows read as zero rather than aliasing onto a real row.
    assign bus.solver_columns = solver_row_ok ? mem[solver_idx] : '0;
    assign bus.host_columns   = host_row_ok ? mem[host_idx] : '0;

    // A row write shadows a simultaneous toggle; out-of-range requests never count as requests.
    assign host_req     = host_row_ok && (bus.host_columns_write || (bus.host_cell_toggle && host_col_ok));
    assign host_grant   = host_req && !bus.solver_active && !busy_q;
    assign solver_wr_ok = bus.solver_columns_write && solver_row_ok && bus.solver_active && !busy_q;
    assign acc_next     = acc + 16'($countones(mem[k_idx]));

    always_ff @(posedge clk) begin
        if (reset) begin
            mem          <= '{default: '0};
            state        <= IDLE;
            k            <= '0;
            acc          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            denied_q     <= 1'b0;
            population_q <= '0;
        end else begin
            done_q   <= 1'b0;
            denied_q <= host_req && !host_grant;

            if (solver_wr_ok) begin
                mem[solver_idx] <= bus.solver_columns_new;
            end
            if (host_grant) begin
                if (bus.host_columns_write) begin
                    mem[host_idx] <= bus.host_columns_new;
                end else begin
                    mem[host_idx][col_idx] <= ~mem[host_idx][col_idx];
                end
            end

            case (state)
                IDLE: begin
                    if (!bus.solver_active) begin
                        if (bus.clear_start) begin
                            state  <= CLEAR;
                            k      <= '0;
                            busy_q <= 1'b1;
                        end else if (bus.count_start) begin
                            state  <= COUNT;
                            k      <= '0;
                            acc    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    mem[k_idx] <= '0;
                    k          <= k + 8'd1;
                    if (k == 8'(ARENA_HEIGHT - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                COUNT: begin
                    acc <= acc_next;
                    k   <= k + 8'd1;
                    if (k == 8'(ARENA_HEIGHT - 1)) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        population_q <= acc_next;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.host_denied = denied_q;
    assign bus.population  = population_q;
endmodule

// File: tb/tb_arena_memory.sv
// Scoreboard bench for arena_memory: a bench-side arena model feeds expected
// values into a queue that is drained as the DUT presents reads and sequencer results.
module tb_arena_memory;
    localparam int unsigned W = 10;
    localparam int unsigned H = 10;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] model [H];
    exp_t sb [$];
    int   busy_n;
    bit   saw_done;

    arena_memory_if #(.ARENA_WIDTH(W)) bus ();

    arena_memory #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %0h expected nothing queued", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < int'(W); i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int model_pop();
        int n = 0;
        for (int r = 0; r < int'(H); r++) n += ones(model[r]);
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            bus.solver_row_select = 8'(r);
            bus.host_row_select   = 8'(r);
            sb_push($sformatf("solver_row%0d", r), 32'((r < int'(H)) ? model[r] : '0));
            sb_push($sformatf("host_row%0d", r), 32'((r < int'(H)) ? model[r] : '0));
            @(negedge clk);
            sb_pop(32'(bus.solver_columns));
            sb_pop(32'(bus.host_columns));
            step();
        end
    endtask

    task automatic host_write(input int row, input logic [W-1:0] data, input bit allowed, input string tag);
        bus.host_row_select    = 8'(row);
        bus.host_columns_new   = data;
        bus.host_columns_write = 1'b1;
        step();
        bus.host_columns_write = 1'b0;
        if (allowed && row < int'(H)) model[row] = data;
        @(negedge clk);
        check(tag, 32'(bus.host_denied), 32'(!allowed && row < int'(H)));
        step();
    endtask

    task automatic run_seq(input bit do_clear, input bit do_count, input bit poke,
                           output int nbusy, output bit got_done);
        bus.clear_start = do_clear;
        bus.count_start = do_count;
        step();
        bus.clear_start = 1'b0;
        bus.count_start = 1'b0;
        nbusy = 0;
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (poke && c == 2) begin
                bus.host_row_select    = 8'd0;
                bus.host_columns_new   = '1;
                bus.host_columns_write = 1'b1;
            end
            @(negedge clk);
            if (poke && c == 3) check("deny_during_clear", 32'(bus.host_denied), 32'd1);
            if (bus.done) got_done = 1'b1;
            else if (bus.busy) nbusy++;
            step();
            bus.host_columns_write = 1'b0;
        end
        if (do_clear) begin
            for (int r = 0; r < int'(H); r++) model[r] = '0;
        end
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        step();
    endtask

    task automatic load_glider();
        host_write(0, W'(10'b0000000010), 1'b1, "glider_r0_denied");
        host_write(1, W'(10'b0000000100), 1'b1, "glider_r1_denied");
        host_write(2, W'(10'b0000000111), 1'b1, "glider_r2_denied");
    endtask

    initial begin
        reset = 1'b1;
        bus.solver_active        = 1'b0;
        bus.solver_row_select    = '0;
        bus.solver_columns_new   = '0;
        bus.solver_columns_write = 1'b0;
        bus.host_row_select      = '0;
        bus.host_col_select      = '0;
        bus.host_columns_new     = '0;
        bus.host_columns_write   = 1'b0;
        bus.host_cell_toggle     = 1'b0;
        bus.clear_start          = 1'b0;
        bus.count_start          = 1'b0;
        for (int r = 0; r < int'(H); r++) model[r] = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_denied", 32'(bus.host_denied), 32'd0);
        check("reset_population", 32'(bus.population), 32'd0);
        step();
        read_rows(0, int'(H) - 1);

        // Host write then single-cell toggle
        host_write(3, W'(10'h2A5), 1'b1, "host_write_denied");
        bus.host_row_select  = 8'd3;
        bus.host_col_select  = 8'd0;
        bus.host_cell_toggle = 1'b1;
        step();
        bus.host_cell_toggle = 1'b0;
        model[3][0] = ~model[3][0];
        read_rows(3, 3);

        // Solver owns the array: host dropped, solver lands
        bus.solver_active = 1'b1;
        host_write(5, W'(10'h3FF), 1'b0, "host_denied_pulse");
        @(negedge clk);
        check("host_denied_clears", 32'(bus.host_denied), 32'd0);
        step();
        bus.solver_row_select    = 8'd5;
        bus.solver_columns_new   = W'(10'h00F);
        bus.solver_columns_write = 1'b1;
        step();
        bus.solver_columns_write = 1'b0;
        model[5] = W'(10'h00F);
        read_rows(5, 5);
        bus.solver_active = 1'b0;
        bus.solver_row_select    = 8'd4;
        bus.solver_columns_new   = W'(10'h155);
        bus.solver_columns_write = 1'b1;
        step();
        bus.solver_columns_write = 1'b0;
        read_rows(4, 4);

        // Start ignored while solver owns the array
        bus.solver_active = 1'b1;
        bus.count_start = 1'b1;
        step();
        bus.count_start = 1'b0;
        bus.solver_active = 1'b0;
        @(negedge clk);
        check("start_ignored_solver", 32'(bus.busy), 32'd0);
        step();

        // Glider population count
        host_write(3, '0, 1'b1, "zero_r3_denied");
        host_write(5, '0, 1'b1, "zero_r5_denied");
        load_glider();
        sb_push("population_glider", 32'(model_pop()));
        run_seq(1'b0, 1'b1, 1'b0, busy_n, saw_done);
        check("count_busy_cycles", 32'(busy_n), 32'(H));
        check("count_done", 32'(saw_done), 32'd1);
        sb_pop(32'(bus.population));

        // Clear and count together: clear wins, population held
        sb_push("population_held", 32'(model_pop()));
        run_seq(1'b1, 1'b1, 1'b0, busy_n, saw_done);
        check("both_done", 32'(saw_done), 32'd1);
        sb_pop(32'(bus.population));
        read_rows(0, int'(H) - 1);

        // Clear after pattern with a host write attempted mid-clear
        load_glider();
        host_write(7, W'(10'h3C3), 1'b1, "r7_denied");
        run_seq(1'b1, 1'b0, 1'b1, busy_n, saw_done);
        check("clear_busy_cycles", 32'(busy_n), 32'(H));
        check("clear_done", 32'(saw_done), 32'd1);
        read_rows(0, int'(H) - 1);
        sb_push("population_after_clear", 32'(model_pop()));
        run_seq(1'b0, 1'b1, 1'b0, busy_n, saw_done);
        sb_pop(32'(bus.population));

        // Out-of-range row/column handling
        read_rows(12, 12);
        host_write(12, W'(10'h3FF), 1'b0, "oob_row_no_deny");
        bus.host_row_select  = 8'd0;
        bus.host_col_select  = 8'd12;
        bus.host_cell_toggle = 1'b1;
        step();
        bus.host_cell_toggle = 1'b0;
        @(negedge clk);
        check("oob_col_no_deny", 32'(bus.host_denied), 32'd0);
        step();
        read_rows(0, 0);

        // Reset mid-clear aborts and zeroes everything
        load_glider();
        sb_push("population_before_abort", 32'(model_pop()));
        run_seq(1'b0, 1'b1, 1'b0, busy_n, saw_done);
        sb_pop(32'(bus.population));
        host_write(8, W'(10'h201), 1'b1, "r8_denied");
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < int'(H); r++) model[r] = '0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_population", 32'(bus.population), 32'd0);
        step();
        read_rows(0, int'(H) - 1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
